// File: rtl/usb_cmd_rx.sv
// usb_cmd_rx: reads 16-bit words from a USB slave FIFO OUT endpoint and
// decodes framed commands (header, cmd, param high, param low, checksum).
// A fetch FSM strobes one word every two cycles when granted, and a
// parser FSM assembles frames with an inter-word idle timeout.
module usb_cmd_rx #(
  parameter logic [15:0] HEADER  = 16'hA55A,
  parameter int          TIMEOUT = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_grant,
  input  logic        i_flagc,
  input  logic [15:0] i_data,
  output logic [1:0]  o_fifoadr,
  output logic        o_sloe,
  output logic        o_slrd,
  output logic        o_busy,
  output logic        o_cmd_come,
  output logic [7:0]  o_cmd,
  output logic [31:0] o_cmd_param,
  output logic        o_err
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    F_IDLE,
    F_RD
  } fetch_t;

  typedef enum logic [2:0] {
    P_HDR,
    P_CMD,
    P_PH,
    P_PL,
    P_SUM
  } parse_t;

  fetch_t        r_fstate;
  fetch_t        w_fNext;
  parse_t        r_pstate;
  parse_t        w_pNext;
  logic [CW-1:0] r_tcnt;
  logic [15:0]   r_w1;
  logic [15:0]   r_ph;
  logic [15:0]   r_pl;
  logic [7:0]    r_cmd;
  logic [31:0]   r_param;
  logic          r_cmdCome;
  logic          r_err;
  logic          w_accept;
  logic          w_timeout;
  logic          w_load;
  logic          w_errSet;
  logic [15:0]   w_sum;

  // A word is accepted at the edge that closes the single read-strobe cycle.
  assign w_accept    = (r_fstate == F_RD);
  assign w_sum       = r_w1 ^ r_ph ^ r_pl;
  assign w_timeout   = (r_pstate != P_HDR) && (r_tcnt == TLAST);

  assign o_fifoadr   = 2'b00;
  assign o_sloe      = ~w_accept;
  assign o_slrd      = ~w_accept;
  assign o_busy      = (r_pstate != P_HDR) || (r_fstate == F_RD);
  assign o_cmd_come  = r_cmdCome;
  assign o_err       = r_err;
  assign o_cmd       = r_cmd;
  assign o_cmd_param = r_param;

  // Fetch state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fstate <= F_IDLE;
    end else begin
      r_fstate <= w_fNext;
    end
  end

  // Fetch next state: start a read when granted with data available; a read
  // always completes in one cycle regardless of grant/flag changes.
  always_comb begin
    w_fNext = r_fstate;
    case (r_fstate)
      F_IDLE:  if (i_grant && i_flagc) w_fNext = F_RD;
      F_RD:    w_fNext = F_IDLE;
      default: w_fNext = F_IDLE;
    endcase
  end

  // Parser state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pstate <= P_HDR;
    end else begin
      r_pstate <= w_pNext;
    end
  end

  // Parser next state and result strobes; an accepted word takes priority
  // over a timeout landing in the same cycle.
  always_comb begin
    w_pNext  = r_pstate;
    w_load   = 1'b0;
    w_errSet = 1'b0;
    if (w_accept) begin
      case (r_pstate)
        P_HDR:   if (i_data == HEADER) w_pNext = P_CMD;
        P_CMD:   w_pNext = P_PH;
        P_PH:    w_pNext = P_PL;
        P_PL:    w_pNext = P_SUM;
        P_SUM: begin
          w_pNext = P_HDR;
          if (i_data == w_sum) begin
            w_load = 1'b1;
          end else begin
            w_errSet = 1'b1;
          end
        end
        default: w_pNext = P_HDR;
      endcase
    end else if (w_timeout) begin
      w_pNext  = P_HDR;
      w_errSet = 1'b1;
    end
  end

  // Inter-word idle counter; only runs while a frame is partially received.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcnt <= '0;
    end else if (w_accept || (r_pstate == P_HDR) || w_timeout) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Capture frame body words as they arrive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w1 <= '0;
      r_ph <= '0;
      r_pl <= '0;
    end else if (w_accept) begin
      case (r_pstate)
        P_CMD:   r_w1 <= i_data;
        P_PH:    r_ph <= i_data;
        P_PL:    r_pl <= i_data;
        default: ;
      endcase
    end
  end

  // Publish a validated command and drive the one-cycle result pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd     <= '0;
      r_param   <= '0;
      r_cmdCome <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cmdCome <= w_load;
      r_err     <= w_errSet;
      if (w_load) begin
        r_cmd   <= r_w1[7:0];
        r_param <= {r_ph, r_pl};
      end
    end
  end

endmodule

// File: tb/tb_usb_cmd_rx.sv
// tb_usb_cmd_rx: directed frames pushed into a slave-FIFO model; expected
// command/error events queued at stimulus time and checked by a monitor.
module tb_usb_cmd_rx;

  localparam int TIMEOUT = 1000;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_grant;
  logic        i_flagc;
  logic [15:0] i_data;
  logic [1:0]  o_fifoadr;
  logic        o_sloe;
  logic        o_slrd;
  logic        o_busy;
  logic        o_cmd_come;
  logic [7:0]  o_cmd;
  logic [31:0] o_cmd_param;
  logic        o_err;

  typedef struct {
    logic        isErr;
    logic [7:0]  cmd;
    logic [31:0] param;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] fifo[$];
  int          nCompared;
  int          nMismatched;
  int          cycle;
  logic [7:0]  modelCmd;
  logic [31:0] modelParam;

  usb_cmd_rx #(
    .HEADER (16'hA55A),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_grant    (i_grant),
    .i_flagc    (i_flagc),
    .i_data     (i_data),
    .o_fifoadr  (o_fifoadr),
    .o_sloe     (o_sloe),
    .o_slrd     (o_slrd),
    .o_busy     (o_busy),
    .o_cmd_come (o_cmd_come),
    .o_cmd      (o_cmd),
    .o_cmd_param(o_cmd_param),
    .o_err      (o_err)
  );

  // Free-running clock and cycle counter.
  initial begin
    i_clk = 1'b0;
    cycle = 0;
    forever begin
      #5 i_clk = 1'b1;
      cycle++;
      #5 i_clk = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [15:0] w);
    fifo.push_back(w);
  endtask

  // Queue a full frame; valid frames update the command model, bad ones
  // expect an error with the previously held command values.
  task automatic applyStimulus(input logic [15:0] w1, input logic [15:0] w2,
                               input logic [15:0] w3, input logic [15:0] w4,
                               input logic isErr, input logic [7:0] cmd,
                               input logic [31:0] param);
    exp_t e;
    pushWord(16'hA55A);
    pushWord(w1);
    pushWord(w2);
    pushWord(w3);
    pushWord(w4);
    if (!isErr) begin
      modelCmd   = cmd;
      modelParam = param;
    end
    e.isErr = isErr;
    e.cmd   = modelCmd;
    e.param = modelParam;
    expQ.push_back(e);
  endtask

  task automatic expectError();
    exp_t e;
    e.isErr = 1'b1;
    e.cmd   = modelCmd;
    e.param = modelParam;
    expQ.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sloe"},    {31'b0, o_sloe}, 32'd1);
    checkOutput({tag, "_slrd"},    {31'b0, o_slrd}, 32'd1);
    checkOutput({tag, "_fifoadr"}, {30'b0, o_fifoadr}, 32'd0);
    checkOutput({tag, "_busy"},    {31'b0, o_busy}, 32'd0);
    checkOutput({tag, "_come"},    {31'b0, o_cmd_come}, 32'd0);
    checkOutput({tag, "_err"},     {31'b0, o_err}, 32'd0);
    checkOutput({tag, "_cmd"},     {24'b0, o_cmd}, 32'd0);
    checkOutput({tag, "_param"},   o_cmd_param, 32'd0);
  endtask

  // Wait until the FIFO is drained, the block is idle and all expected
  // events have been seen; an expired budget counts as a failure.
  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (!(fifo.size() == 0 && !o_busy && expQ.size() == 0) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= budget) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s_timeout: got pending=%0d busy=%0b, required idle", name,
               expQ.size(), o_busy);
      expQ.delete();
      fifo.delete();
    end
  endtask

  task automatic waitFifoEmpty(input int budget);
    int n;
    n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= budget) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL fifo_drain: got %0d words left, required 0", fifo.size());
    end
  endtask

  task automatic waitCome(output int t, input int budget);
    int n;
    n = 0;
    t = -1;
    while (t < 0 && n < budget) begin
      @(negedge i_clk);
      if (o_cmd_come) t = cycle;
      n++;
    end
    if (t < 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL wait_come: got no pulse, required one");
    end
  endtask

  // Slave-FIFO model: presents the head word, pops it during the strobe
  // cycle, and raises the flag while words remain.
  initial begin
    i_data  = 16'h0000;
    i_flagc = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!o_slrd && !o_sloe) begin
        if (fifo.size() > 0) fifo.delete(0);
      end else if (fifo.size() > 0) begin
        i_data = fifo[0];
      end
      i_flagc = (fifo.size() > 0);
    end
  end

  // Monitor: every result pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n === 1'b1 && (o_cmd_come === 1'b1 || o_err === 1'b1)) begin
        if (o_cmd_come && o_err) checkOutput("come_err_exclusive", 32'd1, 32'd0);
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_event: got come=%0b err=%0b, required none",
                   o_cmd_come, o_err);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_is_err", {31'b0, o_err}, {31'b0, e.isErr});
          checkOutput("event_cmd", {24'b0, o_cmd}, {24'b0, e.cmd});
          checkOutput("event_param", o_cmd_param, e.param);
        end
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    int t1;
    int t2;
    nCompared   = 0;
    nMismatched = 0;
    modelCmd    = 8'h00;
    modelParam  = 32'h0;
    i_grant     = 1'b1;
    i_rst_n     = 1'b1;
    #2 i_rst_n  = 1'b0;
    #1 checkResetValues("reset_init");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    $display("[TB] valid frame");
    applyStimulus(16'h0105, 16'h1234, 16'h5678, 16'h4549, 1'b0, 8'h05, 32'h12345678);
    waitIdle("valid", 100);

    $display("[TB] bad checksum");
    applyStimulus(16'h0105, 16'h1234, 16'h5678, 16'h0000, 1'b1, 8'h00, 32'h0);
    waitIdle("badsum", 100);

    $display("[TB] junk then valid frame");
    pushWord(16'h1111);
    pushWord(16'h2222);
    applyStimulus(16'h0105, 16'h1234, 16'h5678, 16'h4549, 1'b0, 8'h05, 32'h12345678);
    waitIdle("resync", 100);

    $display("[TB] timeout mid-frame");
    pushWord(16'hA55A);
    pushWord(16'h0105);
    expectError();
    waitFifoEmpty(50);
    repeat (3) @(negedge i_clk);
    checkOutput("busy_partial", {31'b0, o_busy}, 32'd1);
    repeat (TIMEOUT + 2) @(negedge i_clk);
    checkOutput("busy_after_timeout", {31'b0, o_busy}, 32'd0);
    waitIdle("timeout", 50);
    applyStimulus(16'h00A0, 16'h0001, 16'h0002, 16'h00A3, 1'b0, 8'hA0, 32'h00010002);
    waitIdle("after_timeout", 100);

    $display("[TB] grant withheld");
    i_grant = 1'b0;
    applyStimulus(16'h0105, 16'h1234, 16'h5678, 16'h4549, 1'b0, 8'h05, 32'h12345678);
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      checkOutput("nogrant_strobes", {30'b0, o_sloe, o_slrd}, 32'd3);
    end
    checkOutput("nogrant_fifo_level", fifo.size(), 32'd5);
    i_grant = 1'b1;
    waitIdle("grant", 100);

    $display("[TB] back-to-back frames");
    applyStimulus(16'h7F3C, 16'hDEAD, 16'hBEEF, 16'h1F7E, 1'b0, 8'h3C, 32'hDEADBEEF);
    applyStimulus(16'h1142, 16'hCAFE, 16'h0000, 16'hDBBC, 1'b0, 8'h42, 32'hCAFE0000);
    waitCome(t1, 60);
    waitCome(t2, 60);
    if (t1 >= 0 && t2 >= 0) checkOutput("b2b_gap", t2 - t1, 32'd10);
    waitIdle("b2b", 100);

    $display("[TB] reset mid-frame");
    pushWord(16'hA55A);
    pushWord(16'h0105);
    pushWord(16'h1234);
    waitFifoEmpty(50);
    repeat (3) @(negedge i_clk);
    checkOutput("busy_before_reset", {31'b0, o_busy}, 32'd1);
    i_rst_n = 1'b0;
    modelCmd   = 8'h00;
    modelParam = 32'h0;
    #1 checkResetValues("reset_mid");
    repeat (3) @(negedge i_clk);
    checkResetValues("reset_hold");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    applyStimulus(16'h7F3C, 16'hDEAD, 16'hBEEF, 16'h1F7E, 1'b0, 8'h3C, 32'hDEADBEEF);
    waitIdle("after_reset", 100);
    checkOutput("held_cmd", {24'b0, o_cmd}, 32'h3C);
    checkOutput("held_param", o_cmd_param, 32'hDEADBEEF);

    repeat (5) @(negedge i_clk);
    checkOutput("pending_events", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
